// File: rtl/sonar_varredura_uc.sv
// sonar_varredura_uc: control unit for the sonar sweep.
// Per servo position it triggers one echo measurement and retries on timeout
// up to MAX_RETRIES attempts. It then streams an N_BYTES serial frame, waits
// WAIT_CYCLES for the servo to settle, and steps the servo in wrap-around or
// back-and-forth mode. The byte, retry, settle-timer and position counters
// live in this block.
module sonar_varredura_uc #(
   parameter int unsigned N_BYTES     = 7,
   parameter int unsigned N_POS       = 8,
   parameter int unsigned MAX_RETRIES = 3,
   parameter int unsigned WAIT_CYCLES = 100_000_000
) (
   input  logic                                          clock,
   input  logic                                          reset,
   input  logic                                          ligar,
   input  logic                                          modo,
   input  logic                                          pronto_medida,
   input  logic                                          timeout_echo,
   input  logic                                          pronto_transmissao,
   output logic                                          medir,
   output logic                                          zera_timeout_echo,
   output logic                                          conta_timeout_echo,
   output logic                                          reset_circuito,
   output logic                                          partida_serial,
   output logic [((N_BYTES > 1) ? $clog2(N_BYTES) : 1)-1:0] indice_byte,
   output logic                                          erro_medida,
   output logic                                          conta_angulo,
   output logic [((N_POS > 1) ? $clog2(N_POS) : 1)-1:0]     posicao,
   output logic                                          direcao,
   output logic                                          fim_posicao,
   output logic [2:0]                                    db_estado
);

   localparam int unsigned IW = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
   localparam int unsigned PW = (N_POS > 1) ? $clog2(N_POS) : 1;
   localparam int unsigned RW = (MAX_RETRIES > 1) ? $clog2(MAX_RETRIES) : 1;
   localparam int unsigned TW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

   localparam logic [IW-1:0] IDX_LAST   = IW'(N_BYTES - 1);
   localparam logic [PW-1:0] POS_LAST   = PW'(N_POS - 1);
   localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRIES - 1);
   localparam logic [TW-1:0] TIMER_LAST = TW'(WAIT_CYCLES - 1);

   typedef enum logic [2:0] {
      INICIAL   = 3'd0,
      TRIGGER   = 3'd1,
      AGUARDA   = 3'd2,
      PARTIDA   = 3'd3,
      TRANSMITE = 3'd4,
      PROX_BYTE = 3'd5,
      ESPERA    = 3'd6,
      GIRA      = 3'd7
   } estado_t;

   estado_t       state_q, state_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [RW-1:0] retry_q, retry_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [PW-1:0] pos_q, pos_d;
   logic          dir_q, dir_d;
   logic          erro_q, erro_d;

   // State and counter registers, asynchronously cleared.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= INICIAL;
         idx_q   <= '0;
         retry_q <= '0;
         timer_q <= '0;
         pos_q   <= '0;
         dir_q   <= 1'b0;
         erro_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         retry_q <= retry_d;
         timer_q <= timer_d;
         pos_q   <= pos_d;
         dir_q   <= dir_d;
         erro_q  <= erro_d;
      end
   end

   // Next-state, counter updates and Moore outputs.
   always_comb begin
      state_d            = state_q;
      idx_d              = idx_q;
      retry_d            = retry_q;
      timer_d            = '0;  // held at zero outside ESPERA, so it is clear on entry
      pos_d              = pos_q;
      dir_d              = dir_q;
      erro_d             = erro_q;
      medir              = 1'b0;
      zera_timeout_echo  = 1'b0;
      conta_timeout_echo = 1'b0;
      reset_circuito     = 1'b0;
      partida_serial     = 1'b0;
      conta_angulo       = 1'b0;
      fim_posicao        = 1'b0;

      case (state_q)
         INICIAL: begin
            reset_circuito    = 1'b1;
            zera_timeout_echo = 1'b1;
            idx_d             = '0;
            retry_d           = '0;
            pos_d             = '0;
            dir_d             = 1'b0;
            erro_d            = 1'b0;
            if (ligar) state_d = TRIGGER;
         end
         TRIGGER: begin
            medir             = 1'b1;
            zera_timeout_echo = 1'b1;
            idx_d             = '0;
            state_d           = AGUARDA;
         end
         AGUARDA: begin
            conta_timeout_echo = 1'b1;
            if (pronto_medida) begin
               erro_d  = 1'b0;
               retry_d = '0;
               state_d = PARTIDA;
            end else if (timeout_echo) begin
               if (retry_q == RETRY_LAST) begin
                  erro_d  = 1'b1;
                  retry_d = '0;
                  state_d = PARTIDA;
               end else begin
                  retry_d = retry_q + RW'(1);
                  state_d = TRIGGER;
               end
            end
         end
         PARTIDA: begin
            partida_serial = 1'b1;
            state_d        = TRANSMITE;
         end
         TRANSMITE: begin
            if (pronto_transmissao)
               state_d = (idx_q == IDX_LAST) ? ESPERA : PROX_BYTE;
         end
         PROX_BYTE: begin
            idx_d   = idx_q + IW'(1);
            state_d = PARTIDA;
         end
         ESPERA: begin
            fim_posicao = 1'b1;
            if (timer_q != TIMER_LAST) begin
               timer_d = timer_q + TW'(1);
            end else begin
               timer_d = timer_q;
               if (ligar) state_d = GIRA;
            end
         end
         GIRA: begin
            conta_angulo = 1'b1;
            state_d      = TRIGGER;
            if (!modo) begin
               dir_d = 1'b0;
               pos_d = (pos_q == POS_LAST) ? '0 : pos_q + PW'(1);
            end else if (!dir_q) begin
               if (pos_q == POS_LAST) begin
                  dir_d = 1'b1;
                  pos_d = pos_q - PW'(1);
               end else begin
                  pos_d = pos_q + PW'(1);
               end
            end else begin
               if (pos_q == '0) begin
                  dir_d = 1'b0;
                  pos_d = PW'(1);
               end else begin
                  pos_d = pos_q - PW'(1);
               end
            end
         end
         default: state_d = INICIAL;
      endcase
   end

   assign indice_byte = idx_q;
   assign erro_medida = erro_q;
   assign posicao     = pos_q;
   assign direcao     = dir_q;
   assign db_estado   = state_q;

endmodule

// File: tb/tb_sonar_varredura_uc.sv
// Directed testbench for sonar_varredura_uc with small parameters.
module tb_sonar_varredura_uc;

   localparam int unsigned NB = 3;
   localparam int unsigned NP = 4;
   localparam int unsigned MR = 2;
   localparam int unsigned WC = 5;

   logic       clock = 1'b0;
   logic       reset, ligar, modo, pronto_medida, timeout_echo, pronto_transmissao;
   logic       medir, zera_timeout_echo, conta_timeout_echo, reset_circuito;
   logic       partida_serial, erro_medida, conta_angulo, direcao, fim_posicao;
   logic [1:0] indice_byte;
   logic [1:0] posicao;
   logic [2:0] db_estado;

   int unsigned checks   = 0;
   int unsigned failures = 0;
   int unsigned n_medir   = 0;
   int unsigned n_partida = 0;

   sonar_varredura_uc #(
      .N_BYTES(NB), .N_POS(NP), .MAX_RETRIES(MR), .WAIT_CYCLES(WC)
   ) dut (
      .clock(clock), .reset(reset), .ligar(ligar), .modo(modo),
      .pronto_medida(pronto_medida), .timeout_echo(timeout_echo),
      .pronto_transmissao(pronto_transmissao),
      .medir(medir), .zera_timeout_echo(zera_timeout_echo),
      .conta_timeout_echo(conta_timeout_echo), .reset_circuito(reset_circuito),
      .partida_serial(partida_serial), .indice_byte(indice_byte),
      .erro_medida(erro_medida), .conta_angulo(conta_angulo),
      .posicao(posicao), .direcao(direcao), .fim_posicao(fim_posicao),
      .db_estado(db_estado)
   );

   always #5 clock = ~clock;

   // Strobe counters: each counts the cycles its strobe was high.
   always @(posedge clock) begin
      if (medir)          n_medir   = n_medir + 1;
      if (partida_serial) n_partida = n_partida + 1;
   end

   task automatic check(input string tag, input int unsigned got, input int unsigned exp);
      checks = checks + 1;
      if (got !== exp) begin
         failures = failures + 1;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // From TRIGGER: single attempt answered by pronto_medida, ends in PARTIDA.
   task automatic measure_ok();
      check("trig_state", db_estado, 1);
      check("trig_medir", medir, 1);
      step();
      check("agu_state", db_estado, 2);
      check("agu_conta", conta_timeout_echo, 1);
      pronto_medida = 1'b1;
      step();
      pronto_medida = 1'b0;
      check("ok_partida_state", db_estado, 3);
   endtask

   // From PARTIDA: stream a whole frame, ends in the first ESPERA cycle.
   task automatic send_frame(input int unsigned exp_err);
      int unsigned p0;
      p0 = n_partida;
      for (int b = 0; b < NB; b++) begin
         check("fr_state_partida", db_estado, 3);
         check("fr_partida", partida_serial, 1);
         check("fr_indice", indice_byte, b);
         check("fr_erro", erro_medida, exp_err);
         step();
         check("fr_state_tx", db_estado, 4);
         check("fr_partida_low", partida_serial, 0);
         step();
         check("fr_tx_hold", db_estado, 4);
         check("fr_indice_hold", indice_byte, b);
         pronto_transmissao = 1'b1;
         step();
         pronto_transmissao = 1'b0;
         if (b < NB - 1) begin
            check("fr_prox", db_estado, 5);
            step();
         end
      end
      check("fr_espera", db_estado, 6);
      check("fr_fim", fim_posicao, 1);
      check("fr_npulses", n_partida - p0, NB);
   endtask

   // From first ESPERA cycle with ligar raised: settle, step the servo.
   task automatic advance(input int unsigned exp_pos, input int unsigned exp_dir);
      ligar = 1'b1;
      for (int i = 0; i < WC - 1; i++) begin
         step();
         check("adv_espera", db_estado, 6);
      end
      step();
      check("adv_gira", db_estado, 7);
      check("adv_conta_angulo", conta_angulo, 1);
      ligar = 1'b0;
      step();
      check("adv_trigger", db_estado, 1);
      check("adv_posicao", posicao, exp_pos);
      check("adv_direcao", direcao, exp_dir);
   endtask

   initial begin : stim
      int unsigned m0, p0;
      int unsigned exp_pos[7] = '{1, 2, 3, 2, 1, 0, 1};
      int unsigned exp_dir[7] = '{0, 0, 0, 1, 1, 1, 0};
      reset = 1'b1; ligar = 1'b0; modo = 1'b0;
      pronto_medida = 1'b0; timeout_echo = 1'b0; pronto_transmissao = 1'b0;
      step(); step();
      check("rst_state", db_estado, 0);
      check("rst_reset_circuito", reset_circuito, 1);
      check("rst_zera", zera_timeout_echo, 1);
      check("rst_medir", medir, 0);
      check("rst_conta_to", conta_timeout_echo, 0);
      check("rst_partida", partida_serial, 0);
      check("rst_conta_ang", conta_angulo, 0);
      check("rst_fim", fim_posicao, 0);
      check("rst_erro", erro_medida, 0);
      check("rst_dir", direcao, 0);
      check("rst_pos", posicao, 0);
      check("rst_idx", indice_byte, 0);
      reset = 1'b0;
      step();
      check("idle_state", db_estado, 0);
      ligar = 1'b1;
      step();
      ligar = 1'b0;
      check("start_medir", medir, 1);

      // Position 0: clean measurement.
      measure_ok();
      send_frame(0);
      advance(1, 0);

      // Position 1: two timeouts produce an error frame.
      m0 = n_medir;
      check("to_trig", medir, 1);
      step();
      check("to_agu1", db_estado, 2);
      timeout_echo = 1'b1;
      step();
      check("to_retrigger", db_estado, 1);
      check("to_medir2", medir, 1);
      step();
      check("to_agu2", db_estado, 2);
      step();
      timeout_echo = 1'b0;
      check("to_partida", db_estado, 3);
      check("to_nmedir", n_medir - m0, 2);
      send_frame(1);
      advance(2, 0);

      // Position 2: success clears the error flag.
      measure_ok();
      send_frame(0);
      advance(3, 0);

      // Position 3: pronto_medida wins over a simultaneous timeout.
      m0 = n_medir;
      step();
      check("sim_agu", db_estado, 2);
      pronto_medida = 1'b1; timeout_echo = 1'b1;
      step();
      pronto_medida = 1'b0; timeout_echo = 1'b0;
      check("sim_partida", db_estado, 3);
      check("sim_erro", erro_medida, 0);
      check("sim_nmedir", n_medir - m0, 1);
      send_frame(0);
      advance(0, 0);

      measure_ok();
      send_frame(0);
      advance(1, 0);

      // Position 1: hold in ESPERA while ligar is low.
      measure_ok();
      send_frame(0);
      for (int i = 0; i < 8; i++) begin
         step();
         check("hold_espera", db_estado, 6);
         check("hold_fim", fim_posicao, 1);
      end
      ligar = 1'b1;
      step();
      check("hold_gira", conta_angulo, 1);
      ligar = 1'b0;
      step();
      check("hold_pos", posicao, 2);

      // Position 2: reset in the middle of a frame.
      measure_ok();
      step();
      check("abort_tx", db_estado, 4);
      p0 = n_partida;
      reset = 1'b1;
      #1;
      check("abort_state", db_estado, 0);
      check("abort_pos", posicao, 0);
      pronto_transmissao = 1'b1;
      step(); step();
      pronto_transmissao = 1'b0;
      reset = 1'b0;
      step(); step();
      check("abort_state_after", db_estado, 0);
      check("abort_no_partida", n_partida - p0, 0);

      // Back-and-forth sweep from position 0.
      modo = 1'b1;
      ligar = 1'b1;
      step();
      ligar = 1'b0;
      for (int k = 0; k < 7; k++) begin
         measure_ok();
         send_frame(0);
         advance(exp_pos[k], exp_dir[k]);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sonar_varredura_uc.md
# sonar_varredura_uc

Parametrised control unit for the sonar scanning system. It sequences one echo measurement per servo position, with bounded automatic retries on echo timeout. It then streams an N-byte serial frame, holds the position for a programmable settle interval, and steps the servo in either wrap-around or back-and-forth mode. Byte, retry, settle-timer and position counters are internal, so the datapath only supplies the measurement, timeout and transmitter handshakes.

## Interface
- N_BYTES, 7: bytes per transmitted frame (≥1)
- N_POS, 8: servo positions per sweep (≥2)
- MAX_RETRIES, 3: measurement attempts per position before error frame (≥1)
- WAIT_CYCLES, 100_000_000: settle interval in clock cycles (≥1; 2 s at 50 MHz)

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; forces INICIAL and reset values below
- ligar  in  1  enable; sampled only in INICIAL and ESPERA
- modo  in  1  0 = wrap sweep, 1 = back-and-forth sweep; sampled in GIRA
- pronto_medida  in  1  echo measurement complete (pulse)
- timeout_echo  in  1  external echo timeout expired
- pronto_transmissao  in  1  serial transmitter finished current byte (pulse)
- medir  out  1  trigger pulse to the measurement block
- zera_timeout_echo  out  1  clear external timeout counter
- conta_timeout_echo  out  1  enable external timeout counter
- reset_circuito  out  1  datapath reset
- partida_serial  out  1  start one serial byte
- indice_byte  out  max(1,$clog2(N_BYTES))  byte of frame currently selected
- erro_medida  out  1  current frame reports failed measurement
- conta_angulo  out  1  servo step strobe
- posicao  out  max(1,$clog2(N_POS))  current servo position index
- direcao  out  1  sweep direction, 0 = up, 1 = down
- fim_posicao  out  1  frame done, settling
- db_estado  out  3  state code

## Operation
Moore FSM. State codes are in parentheses.
- INICIAL (0)
  - Outputs: reset_circuito = 1, zera_timeout_echo = 1.
  - Clears indice_byte, retry counter, timer, posicao, direcao and erro_medida.
  - Goes to TRIGGER when ligar = 1; otherwise stays.
- TRIGGER (1)
  - Outputs: medir = 1, zera_timeout_echo = 1.
  - Clears indice_byte. Goes to AGUARDA.
- AGUARDA (2)
  - Output: conta_timeout_echo = 1.
  - On pronto_medida: go to PARTIDA, erro_medida ← 0, retry ← 0.
  - Otherwise, on timeout_echo with retry = MAX_RETRIES−1: go to PARTIDA, erro_medida ← 1, retry ← 0.
  - Otherwise, on timeout_echo: retry ← retry+1, go to TRIGGER.
  - With neither input: stay.
- PARTIDA (3)
  - Output: partida_serial = 1.
  - Goes to TRANSMITE.
- TRANSMITE (4)
  - Waits for pronto_transmissao.
  - Then goes to ESPERA if indice_byte = N_BYTES−1; otherwise to PROX_BYTE.
- PROX_BYTE (5)
  - indice_byte ← indice_byte+1. Goes to PARTIDA.
- ESPERA (6)
  - Output: fim_posicao = 1.
  - Timer is cleared on entry, counts each cycle and saturates at WAIT_CYCLES−1.
  - Goes to GIRA when the timer is saturated and ligar = 1.
- GIRA (7)
  - Output: conta_angulo = 1.
  - Updates posicao, then goes to TRIGGER.

Position update in GIRA:
- modo = 0: posicao ← (posicao = N_POS−1) ? 0 : posicao+1. direcao is held at 0.
- modo = 1, direcao = 0: if posicao = N_POS−1, then direcao ← 1 and posicao ← posicao−1; else posicao+1.
- modo = 1, direcao = 1: if posicao = 0, then direcao ← 0 and posicao ← 1; else posicao−1.
- Switching modo from 1 to 0 forces direcao ← 0 in that GIRA.

General rules:
- erro_medida holds its value from the AGUARDA exit until the next AGUARDA exit.
- All counters are unsigned and never exceed their terminal values.
- Unused state encodings go to INICIAL.

## Timing
- Reset values: db_estado = 0, reset_circuito = 1, zera_timeout_echo = 1. All other outputs are 0: medir, conta_timeout_echo, partida_serial, conta_angulo, fim_posicao, erro_medida, direcao, posicao, indice_byte.
- Every strobe (medir, partida_serial, conta_angulo) is exactly 1 cycle wide per state visit.
- The cycle after ligar is seen in INICIAL, medir = 1.
- One frame produces exactly N_BYTES partida_serial pulses. indice_byte is stable from each pulse until the matching pronto_transmissao.
- pronto_medida has priority over timeout_echo when both arrive in the same cycle.
- pronto_transmissao is ignored outside TRANSMITE; pronto_medida and timeout_echo are ignored outside AGUARDA.
- ESPERA lasts at least WAIT_CYCLES cycles. If ligar = 0 at saturation, the block waits without further counting.
- Reset mid-frame aborts immediately; no further partida_serial is issued.

## Test plan
Bench parameters: N_BYTES = 3, N_POS = 4, MAX_RETRIES = 2, WAIT_CYCLES = 5.
- Reset then ligar = 1: next cycle medir = 1. A pronto_medida response leads to 3 partida_serial pulses with indice_byte 0, 1, 2, and erro_medida = 0.
- Two consecutive timeout_echo: medir pulses twice, then a frame is sent with erro_medida = 1. The next position with pronto_medida clears erro_medida.
- Simultaneous pronto_medida and timeout_echo on the first attempt: exits to PARTIDA with erro_medida = 0 and no second medir.
- modo = 0 over 5 GIRA visits: posicao sequence 1, 2, 3, 0, 1, with direcao = 0.
- modo = 1 from posicao 0 over 7 GIRA visits: posicao 1, 2, 3, 2, 1, 0, 1. direcao rises at the 3→2 step and falls at the 0→1 step.
- ligar = 0 in ESPERA: fim_posicao stays 1 for more than 5 cycles. Raising ligar gives conta_angulo on the following cycle. A reset pulse during TRANSMITE returns to db_estado = 0 with posicao = 0.
